// File: rtl/canny_seq_pkg.sv
// Shared definitions for the Canny frame sequencer.
// - seq_state_e : output-side FSM encoding (idle, control packet, pixel stream)
// - META_W and field offsets for the packed {width, height, interlaced} metadata word
// - default frame geometry used after reset until a control packet arrives
// - helpers to pack metadata and to compute the pixel count of a frame
package canny_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCtrl   = 2'd1,
    StStream = 2'd2
  } seq_state_e;

  localparam int unsigned META_W     = 36;
  localparam int unsigned WIDTH_LSB  = 20;
  localparam int unsigned HEIGHT_LSB = 4;
  localparam int unsigned INTL_LSB   = 0;

  localparam logic [15:0] DEF_WIDTH      = 16'd1920;
  localparam logic [15:0] DEF_HEIGHT     = 16'd1080;
  localparam logic [3:0]  DEF_INTERLACED = 4'd0;

  function automatic logic [META_W-1:0] meta_pack(input logic [15:0] w, input logic [15:0] h,
                                                  input logic [3:0] il);
    return {w, h, il};
  endfunction

  // Full 32-bit product; a 16x16 frame size never truncates.
  function automatic logic [31:0] meta_pixels(input logic [META_W-1:0] m);
    return {16'd0, m[WIDTH_LSB +: 16]} * {16'd0, m[HEIGHT_LSB +: 16]};
  endfunction

endpackage

// File: rtl/canny_meta_fifo.sv
// Synchronous FIFO for per-frame metadata.
// Ports: clk/rst (async, active-high), push_i/wdata_i write side, pop_i/rdata_o read side
// (rdata_o shows the head combinationally), full_o/empty_o status.
// Push and pop may occur in the same cycle at any occupancy; a push while full is only
// accepted if the same cycle also pops, so full+push+pop stays full.
module canny_meta_fifo
  import canny_seq_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = META_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to separate full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en = push_i && (!full_o || pop_i);
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame-level controller for the Canny video core.
// Input side: latches VIP control packet fields, queues one metadata word per input frame
// (first accepted pixel), and raises in_hold when no further frame may start.
// Output side: per frame, loads width/height/interlaced_out, pulses vip_ctrl_send once the
// encoder is free, then streams exactly width*height pixels (write/dp_out_rd) and flags
// end_of_video_out on the last one.
// Ports: clk, rst (async, active-high); vip_ctrl_valid/width_in/height_in/interlaced_in;
// in_pixel_accept/in_eov/in_hold; dp_out_valid/dp_out_rd/stall_out/write/end_of_video_out;
// width_out/height_out/interlaced_out/vip_ctrl_busy/vip_ctrl_send; frame_count/pix_err.
// Build option: define CANNY_SEQ_STATS_EN for a live frame_count and the sticky pix_err
// input pixel-count check; otherwise both outputs are tied to 0.
module canny_frame_sequencer
  import canny_seq_pkg::*;
#(
  parameter int unsigned META_DEPTH         = 4,
  parameter logic [15:0] DEFAULT_WIDTH      = DEF_WIDTH,
  parameter logic [15:0] DEFAULT_HEIGHT     = DEF_HEIGHT,
  parameter logic [3:0]  DEFAULT_INTERLACED = DEF_INTERLACED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vip_ctrl_valid,
  input  logic [15:0] width_in,
  input  logic [15:0] height_in,
  input  logic [3:0]  interlaced_in,
  input  logic        in_pixel_accept,
  input  logic        in_eov,
  output logic        in_hold,
  input  logic        dp_out_valid,
  output logic        dp_out_rd,
  input  logic        stall_out,
  output logic        write,
  output logic        end_of_video_out,
  output logic [15:0] width_out,
  output logic [15:0] height_out,
  output logic [3:0]  interlaced_out,
  input  logic        vip_ctrl_busy,
  output logic        vip_ctrl_send,
  output logic [15:0] frame_count,
  output logic        pix_err
);

  localparam logic [META_W-1:0] MetaDefault =
    {DEFAULT_WIDTH, DEFAULT_HEIGHT, DEFAULT_INTERLACED};

  logic [META_W-1:0] meta_q, push_meta, head;
  logic              in_frame_q;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  seq_state_e        state_q;
  logic [15:0]       width_q, height_q;
  logic [3:0]        intl_q;
  logic [31:0]       exp_q, out_cnt_q;
  logic              send_q, last_wr;

  // ---------------- input side ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) meta_q <= MetaDefault;
    else if (vip_ctrl_valid) meta_q <= meta_pack(width_in, height_in, interlaced_in);
  end

  // Fields arriving with the first pixel bypass the meta register.
  assign push_meta = vip_ctrl_valid ? meta_pack(width_in, height_in, interlaced_in) : meta_q;
  assign fifo_push = in_pixel_accept && !in_frame_q;
  assign in_hold   = fifo_full && !in_frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame_q <= 1'b0;
    end else if (in_pixel_accept) begin
      if (in_eov)           in_frame_q <= 1'b0;
      else if (!in_frame_q) in_frame_q <= 1'b1;
    end
  end

  canny_meta_fifo #(
    .Depth(META_DEPTH),
    .Width(META_W)
  ) u_meta_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .wdata_i(push_meta),
    .pop_i  (fifo_pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // ---------------- output side ----------------
  assign write            = (state_q == StStream) && dp_out_valid && !stall_out;
  assign dp_out_rd        = write;
  assign last_wr          = write && (out_cnt_q == exp_q - 32'd1);
  assign end_of_video_out = last_wr;
  // Zero-size frames are dropped from CTRL without a send pulse.
  assign fifo_pop         = ((state_q == StCtrl) && (exp_q == 32'd0)) || last_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      width_q   <= DEFAULT_WIDTH;
      height_q  <= DEFAULT_HEIGHT;
      intl_q    <= DEFAULT_INTERLACED;
      exp_q     <= '0;
      out_cnt_q <= '0;
      send_q    <= 1'b0;
    end else begin
      send_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            width_q  <= head[WIDTH_LSB +: 16];
            height_q <= head[HEIGHT_LSB +: 16];
            intl_q   <= head[INTL_LSB +: 4];
            exp_q    <= meta_pixels(head);
            state_q  <= StCtrl;
          end
        end
        StCtrl: begin
          if (exp_q == 32'd0) begin
            state_q <= StIdle;
          end else if (!vip_ctrl_busy) begin
            send_q  <= 1'b1;
            state_q <= StStream;
          end
        end
        StStream: begin
          if (last_wr) begin
            out_cnt_q <= '0;
            state_q   <= StIdle;
          end else if (write) begin
            out_cnt_q <= out_cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign width_out      = width_q;
  assign height_out     = height_q;
  assign interlaced_out = intl_q;
  assign vip_ctrl_send  = send_q;

`ifdef CANNY_SEQ_STATS_EN
  logic [15:0]       frame_cnt_q;
  logic              pix_err_q;
  logic [31:0]       in_cnt_q, in_exp;
  logic [META_W-1:0] in_meta_q;

  // A single-pixel frame has no captured meta yet; use the word being pushed.
  assign in_exp = in_frame_q ? meta_pixels(in_meta_q) : meta_pixels(push_meta);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      pix_err_q   <= 1'b0;
      in_cnt_q    <= '0;
      in_meta_q   <= MetaDefault;
    end else begin
      if (last_wr)   frame_cnt_q <= frame_cnt_q + 16'd1;
      if (fifo_push) in_meta_q   <= push_meta;
      if (in_pixel_accept) begin
        if (in_eov) begin
          in_cnt_q <= '0;
          if (in_cnt_q + 32'd1 != in_exp) pix_err_q <= 1'b1;
        end else begin
          in_cnt_q <= in_cnt_q + 32'd1;
        end
      end
    end
  end

  assign frame_count = frame_cnt_q;
  assign pix_err     = pix_err_q;
`else
  assign frame_count = '0;
  assign pix_err     = 1'b0;
`endif

endmodule

// File: tb/tb_canny_frame_sequencer.sv
module tb_canny_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vip_ctrl_valid = 1'b0;
  logic [15:0] width_in = '0, height_in = '0;
  logic [3:0]  interlaced_in = '0;
  logic        in_pixel_accept = 1'b0, in_eov = 1'b0;
  logic        in_hold;
  logic        dp_out_valid, dp_out_rd;
  logic        stall_out = 1'b0;
  logic        write, end_of_video_out;
  logic [15:0] width_out, height_out;
  logic [3:0]  interlaced_out;
  logic        vip_ctrl_busy = 1'b0;
  logic        vip_ctrl_send;
  logic [15:0] frame_count;
  logic        pix_err;

  always #5 clk = ~clk;

  canny_frame_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .vip_ctrl_valid  (vip_ctrl_valid),
    .width_in        (width_in),
    .height_in       (height_in),
    .interlaced_in   (interlaced_in),
    .in_pixel_accept (in_pixel_accept),
    .in_eov          (in_eov),
    .in_hold         (in_hold),
    .dp_out_valid    (dp_out_valid),
    .dp_out_rd       (dp_out_rd),
    .stall_out       (stall_out),
    .write           (write),
    .end_of_video_out(end_of_video_out),
    .width_out       (width_out),
    .height_out      (height_out),
    .interlaced_out  (interlaced_out),
    .vip_ctrl_busy   (vip_ctrl_busy),
    .vip_ctrl_send   (vip_ctrl_send),
    .frame_count     (frame_count),
    .pix_err         (pix_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int unsigned w;
    int unsigned h;
    int unsigned il;
  } frame_t;

  frame_t sb[$];
  frame_t mon_f;

  // Bench model of the input-side meta register.
  int unsigned model_w = 1920, model_h = 1080, model_il = 0;

  // Pixel datapath stand-in: holds every accepted input pixel until popped.
  int dp_avail = 0;
  assign dp_out_valid = (dp_avail > 0);
  always @(posedge clk or posedge rst) begin
    if (rst) dp_avail <= 0;
    else dp_avail <= dp_avail + (in_pixel_accept ? 1 : 0) - (dp_out_rd ? 1 : 0);
  end

  // Output monitor: pops the scoreboard on each send pulse, then checks every write.
  bit          sent = 0;
  int unsigned cur_exp = 0, cur_writes = 0, last_writes = 0;
  int unsigned frames_done = 0, sends_seen = 0, frames_at_reset = 0;

  always @(negedge clk) begin
    if (rst) begin
      sent = 0;
      cur_writes = 0;
    end else begin
      if (vip_ctrl_send) begin
        sends_seen++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL send_order: send pulse seen, scoreboard empty");
        end else begin
          mon_f = sb.pop_front();
          if (width_out !== 16'(mon_f.w) || height_out !== 16'(mon_f.h) ||
              interlaced_out !== 4'(mon_f.il)) begin
            n_err++;
            $display("FAIL ctrl_fields: got %0d x %0d il %0d, want %0d x %0d il %0d",
                     width_out, height_out, interlaced_out, mon_f.w, mon_f.h, mon_f.il);
          end
          cur_exp = mon_f.w * mon_f.h;
        end
        sent = 1;
        cur_writes = 0;
      end
      if (write) begin
        n_cmp++;
        if (!sent || stall_out || !dp_out_valid || dp_out_rd !== 1'b1) begin
          n_err++;
          $display("FAIL write_gate: write=1 sent=%0d stall=%0b valid=%0b rd=%0b, want sent=1",
                   sent, stall_out, dp_out_valid, dp_out_rd);
        end
        cur_writes++;
        n_cmp++;
        if (end_of_video_out !== (cur_writes == cur_exp)) begin
          n_err++;
          $display("FAIL eov_pos: eov=%0b on write %0d, want eov only on write %0d",
                   end_of_video_out, cur_writes, cur_exp);
        end
        if (end_of_video_out) begin
          sent = 0;
          last_writes = cur_writes;
          frames_done++;
        end
      end else begin
        n_cmp++;
        if (end_of_video_out !== 1'b0 || dp_out_rd !== 1'b0) begin
          n_err++;
          $display("FAIL idle_out: eov=%0b rd=%0b without write, want 0 0",
                   end_of_video_out, dp_out_rd);
        end
      end
    end
  end

  function automatic logic [15:0] exp_fc();
`ifdef CANNY_SEQ_STATS_EN
    return 16'(frames_done - frames_at_reset);
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: no control packet, 1: control packet the cycle before, 2: with the first pixel.
  task automatic drive_frame(input int unsigned w, input int unsigned h, input int mode,
                             input int unsigned il, input int npix, input int eov_idx);
    int waited = 0;
    if (mode != 0) begin
      model_w = w;
      model_h = h;
      model_il = il;
    end
    if (mode == 1) begin
      vip_ctrl_valid = 1'b1;
      width_in = 16'(w);
      height_in = 16'(h);
      interlaced_in = 4'(il);
      tick();
      vip_ctrl_valid = 1'b0;
    end
    while (in_hold && waited < 300) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (in_hold !== 1'b0) begin
      n_err++;
      $display("FAIL hold_timeout: in_hold=%0b after %0d cycles, want 0", in_hold, waited);
    end
    sb.push_back('{model_w, model_h, model_il});
    for (int i = 0; i < npix; i++) begin
      if (mode == 2 && i == 0) begin
        vip_ctrl_valid = 1'b1;
        width_in = 16'(w);
        height_in = 16'(h);
        interlaced_in = 4'(il);
      end
      in_pixel_accept = 1'b1;
      in_eov = (i == eov_idx);
      tick();
      vip_ctrl_valid = 1'b0;
    end
    in_pixel_accept = 1'b0;
    in_eov = 1'b0;
  endtask

  task automatic wait_frames(input int unsigned target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (frames_done < target) begin
      n_err++;
      $display("FAIL frame_timeout: frames done %0d, want %0d", frames_done, target);
    end
  endtask

  task automatic check_frame(input string name, input int unsigned writes);
    n_cmp++;
    if (last_writes !== writes) begin
      n_err++;
      $display("FAIL %s_writes: got %0d writes, want %0d", name, last_writes, writes);
    end
    n_cmp++;
    if (frame_count !== exp_fc()) begin
      n_err++;
      $display("FAIL %s_frame_count: got %0d, want %0d", name, frame_count, exp_fc());
    end
  endtask

  task automatic check_reset_state(input string name);
    n_cmp++;
    if (width_out !== 16'd1920 || height_out !== 16'd1080 || interlaced_out !== 4'd0) begin
      n_err++;
      $display("FAIL %s_dims: got %0d x %0d il %0d, want 1920 x 1080 il 0",
               name, width_out, height_out, interlaced_out);
    end
    n_cmp++;
    if (vip_ctrl_send !== 1'b0 || write !== 1'b0 || end_of_video_out !== 1'b0 ||
        in_hold !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ctrl: send=%0b write=%0b eov=%0b hold=%0b, want all 0",
               name, vip_ctrl_send, write, end_of_video_out, in_hold);
    end
    n_cmp++;
    if (frame_count !== 16'd0 || pix_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s_stats: frame_count=%0d pix_err=%0b, want 0 0",
               name, frame_count, pix_err);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb.delete();
    model_w = 1920;
    model_h = 1080;
    model_il = 0;
    stall_out = 1'b0;
    vip_ctrl_busy = 1'b0;
    in_pixel_accept = 1'b0;
    in_eov = 1'b0;
    tick();
    check_reset_state("reset_hold");
    frames_at_reset = frames_done;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check_reset_state("reset_release");
  endtask

  task automatic test_single_frame();
    int unsigned base = frames_done;
    drive_frame(4, 2, 1, 0, 8, 7);
    wait_frames(base + 1, 100);
    tick();
    check_frame("single", 8);
  endtask

  task automatic test_reuse_meta();
    int unsigned base = frames_done;
    drive_frame(0, 0, 0, 0, 8, 7);
    wait_frames(base + 1, 100);
    tick();
    check_frame("reuse", 8);
  endtask

  task automatic test_busy();
    int unsigned base = frames_done;
    int unsigned s0 = sends_seen;
    vip_ctrl_busy = 1'b1;
    drive_frame(0, 0, 0, 0, 8, 7);
    repeat (5) tick();
    n_cmp++;
    if (sends_seen !== s0 || vip_ctrl_send !== 1'b0) begin
      n_err++;
      $display("FAIL busy_hold: sends=%0d send=%0b while busy, want %0d 0",
               sends_seen, vip_ctrl_send, s0);
    end
    vip_ctrl_busy = 1'b0;
    tick();
    n_cmp++;
    if (vip_ctrl_send !== 1'b1) begin
      n_err++;
      $display("FAIL busy_release: send=%0b cycle after busy drop, want 1", vip_ctrl_send);
    end
    wait_frames(base + 1, 100);
    tick();
    check_frame("busy", 8);
  endtask

  task automatic test_stall_toggle();
    int unsigned base = frames_done;
    fork
      drive_frame(3, 3, 2, 2, 9, 8);
      begin
        for (int k = 0; k < 200 && frames_done < base + 1; k++) begin
          stall_out = ~stall_out;
          tick();
        end
        stall_out = 1'b0;
      end
    join
    wait_frames(base + 1, 50);
    tick();
    check_frame("stall", 9);
  endtask

  task automatic test_back_to_back();
    int unsigned base = frames_done;
    stall_out = 1'b1;
    for (int i = 0; i < 4; i++) drive_frame(2, 2, 1, i + 1, 4, 3);
    tick();
    n_cmp++;
    if (in_hold !== 1'b1) begin
      n_err++;
      $display("FAIL hold_assert: in_hold=%0b with queue full, want 1", in_hold);
    end
    fork
      drive_frame(2, 2, 1, 5, 4, 3);
      begin
        repeat (6) tick();
        stall_out = 1'b0;
      end
      begin
        int n = 0;
        while (in_hold && n < 300) begin
          tick();
          n++;
        end
        n_cmp++;
        if (frames_done !== base + 1) begin
          n_err++;
          $display("FAIL hold_release: released after %0d frames out, want %0d",
                   frames_done - base, 1);
        end
      end
    join
    wait_frames(base + 5, 300);
    tick();
    check_frame("backlog", 4);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL backlog_drain: %0d frames never sent, want 0", sb.size());
    end
  endtask

  task automatic test_err_and_reset();
    logic want_err;
`ifdef CANNY_SEQ_STATS_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    drive_frame(4, 2, 1, 0, 7, 6);
    repeat (3) tick();
    n_cmp++;
    if (pix_err !== want_err) begin
      n_err++;
      $display("FAIL pix_err_set: got %0b, want %0b", pix_err, want_err);
    end
    drive_frame(0, 0, 0, 0, 8, 7);
    repeat (5) tick();
    n_cmp++;
    if (pix_err !== want_err) begin
      n_err++;
      $display("FAIL pix_err_sticky: got %0b, want %0b", pix_err, want_err);
    end
    apply_reset();
    check_reset_state("after_reset");
  endtask

  task automatic test_after_reset();
    int unsigned base = frames_done;
    drive_frame(2, 3, 2, 1, 6, 5);
    wait_frames(base + 1, 100);
    tick();
    check_frame("post_reset", 6);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_reuse_meta();
    test_busy();
    test_stall_toggle();
    test_back_to_back();
    test_err_and_reset();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/canny_frame_sequencer.md
Name: canny_frame_sequencer

Overview:
Frame-level controller for the Canny video core. It tracks Avalon-ST Video (VIP) control packets (width/height/interlaced) on the input side and queues per-frame metadata. It then sequences the output side: one control packet is sent per frame, pixel writes are gated until it is issued, output pixels are counted, and end_of_video_out is flagged on the last pixel. The block sits between the VIP flow-control wrapper and the grayscale/Canny pixel datapath and replaces ad-hoc per-signal control FIFOs.

Parameters:
META_DEPTH, 4, frames of metadata in flight (power of 2, >=2)
DEFAULT_WIDTH, 1920, width_out/meta width after reset until first control packet
DEFAULT_HEIGHT, 1080, height used likewise
DEFAULT_INTERLACED, 0, interlaced nibble used likewise

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
vip_ctrl_valid  in  1  control packet fields valid this cycle
width_in  in  16  decoded width
height_in  in  16  decoded height
interlaced_in  in  4  decoded interlaced nibble
in_pixel_accept  in  1  datapath accepted an input pixel this cycle
in_eov  in  1  end_of_video qualifier on the accepted pixel
in_hold  out  1  forbid starting a new input frame (wrapper stalls read)
dp_out_valid  in  1  datapath has an output pixel at its head
dp_out_rd  out  1  pop datapath output pixel (combinational)
stall_out  in  1  downstream stall
write  out  1  output pixel write strobe (combinational)
end_of_video_out  out  1  last pixel of frame, coincident with write
width_out  out  16  registered, to control packet encoder
height_out  out  16  registered
interlaced_out  out  4  registered
vip_ctrl_busy  in  1  encoder busy
vip_ctrl_send  out  1  registered one-cycle send pulse
frame_count  out  16  frames completed on output (feature-gated)
pix_err  out  1  sticky input pixel-count mismatch (feature-gated)

Behaviour:
- Reset: meta register = defaults; queue empty; in_frame=0; in_cnt=0, out_cnt=0; state=IDLE; width_out/height_out/interlaced_out = defaults; vip_ctrl_send=0; frame_count=0; pix_err=0.
- Meta register: loaded on vip_ctrl_valid; holds the last value otherwise.
- Input side: in_pixel_accept && !in_frame pushes {width,height,interlaced} into queue, sets in_frame. If vip_ctrl_valid is high the same cycle, the new fields are pushed (bypass).
- in_hold = queue full && !in_frame. A push never occurs while full.
- in_cnt increments per accepted pixel. in_pixel_accept && in_eov clears in_frame and in_cnt.
- A frame without a preceding control packet reuses the meta register value.
- Output FSM:
  - IDLE: queue non-empty -> load *_out regs from head; go CTRL.
  - CTRL: wait until !vip_ctrl_busy; then pulse vip_ctrl_send for exactly 1 cycle and go STREAM. If expected=0, go directly to IDLE and pop instead.
  - STREAM: dp_out_rd = write = dp_out_valid && !stall_out. out_cnt increments on each write. On the write where out_cnt == expected-1: end_of_video_out=1, pop queue, out_cnt=0, frame_count+1, go IDLE.
- write, dp_out_rd and end_of_video_out are 0 outside STREAM. No pixel is ever written before that frame's send pulse.
- expected = width*height, 32-bit unsigned, no truncation.
- Latency: queue push -> vip_ctrl_send at earliest 2 cycles (IDLE, CTRL). After the last write, the next frame's CTRL is reached in 2 cycles.
- Simultaneous push and pop is allowed in any occupancy. Full+pop+push leaves the queue full.
- The output frame end is decided by out_cnt, never by in_eov.
- Reset mid-frame: all state is cleared immediately (async); no partial eov is emitted.

Optional Feature:
Macro CANNY_SEQ_STATS_EN.
- Defined: frame_count is live. At in_pixel_accept && in_eov, if in_cnt+1 != width*height of the current input frame's meta, pix_err is set sticky until rst.
- Undefined: frame_count and pix_err are tied to 0 and the comparator and counter are not synthesised.

Decomposition:
- Shared package canny_seq_pkg: FSM state encodings (IDLE, CTRL, STREAM), META_W=36 and field offsets, default constants.
- One sub-module: canny_meta_fifo, a synchronous FIFO (META_DEPTH x 36) with full/empty/push/pop and same-cycle push+pop.

Test Plan:
- Ctrl packet 4x2, 8 pixels with eov on the 8th, no stall -> one send pulse with width_out=4/height_out=2; 8 writes; eov only on the 8th; frame_count=1.
- Second 4x2 frame with no control packet -> second send pulse with repeated 4x2; eov on write 8; frame_count=2.
- vip_ctrl_busy held high 5 cycles in CTRL -> send fires the cycle after busy drops; zero writes before it.
- stall_out toggling every cycle during a 3x3 frame -> write/dp_out_rd never high while stalled; exactly 9 writes; eov on the 9th.
- Input runs 5 frames of 2x2 ahead while output is stalled with META_DEPTH=4 -> in_hold asserts on the 5th frame start; releases after the first output eov; all frames are sent in order.
- With CANNY_SEQ_STATS_EN: 4x2 control packet, eov on pixel 7 -> pix_err=1 and stays 1; rst -> pix_err=0 and width_out=1920.
